writeback_regfile: RTL and testbench

Consumer end of the MEM/WB pipeline register. Takes `wb_data`, `rd`, `is_write` and `mov_rm` and commits them into the 32-entry general register file (GPR) or the special register bank (RM). Provides decode-stage read ports with same-cycle writeback bypass. Also records exception state into the RM bank and counts retired writes.

---
 rtl/writeback_regfile_pkg.sv | 28 ++
 rtl/writeback_regfile_bank.sv | 34 +++
 rtl/writeback_regfile.sv | 142 ++++++++++++++
 tb/tb_writeback_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared writeback-stage constants: special register (RM) map and datapath width.
package writeback_regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int GPR_DEPTH = 32;
    localparam int RM_DEPTH  = 8;

    localparam int RM_EPC    = 0;
    localparam int RM_EADDR  = 1;
    localparam int RM_CAUSE  = 2;
    localparam int RM_STATUS = 3;

    localparam int RM_STATUS_EXC_BIT = 0;

    // Exception payload as committed into the RM bank.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] cause;
    } exc_req_t;

    // RM indices 0..3 are owned by the exception commit when it fires.
    function automatic logic exc_owns_rm(input int idx);
        return idx <= RM_STATUS;
    endfunction

endpackage

// File: rtl/writeback_regfile_bank.sv
// Register bank: per-entry synchronous write enables, NRD combinational read ports.
module regfile_bank #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DEPTH-1:0]           we_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] wdata_i,
    input  logic [NRD-1:0][AW-1:0]     raddr_i,
    output logic [NRD-1:0][WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Per-entry enables let the RM bank take an exception commit and an
    // ordinary write on the same edge; the GPR bank drives a one-hot.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q[e] <= '0;
            end else if (we_i[e]) begin
                mem_q[e] <= wdata_i[e];
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign rdata_o[r] = mem_q[raddr_i[r]];
    end

endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: commits writeback into GPR or RM, records exceptions,
// provides bypassed decode read ports and a retired-write counter.
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int NUM_RM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wb_data_in,
    input  logic [4:0]        rd_in,
    input  logic              is_write_in,
    input  logic              mov_rm_in,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [2:0]        rm_addr,
    output logic [DATA_W-1:0] rm_data,
    input  logic              exc_valid,
    input  logic [DATA_W-1:0] exc_pc,
    input  logic [DATA_W-1:0] exc_addr,
    input  logic [DATA_W-1:0] exc_cause,
    output logic              wb_fire,
    output logic [31:0]       retire_count
);
    import writeback_regfile_pkg::*;

    localparam int NGPR = 32;

    logic                          gpr_we;
    logic                          rm_we;
    logic [2:0]                    rm_widx;
    logic [NGPR-1:0]               gpr_wen;
    logic [NGPR-1:0][DATA_W-1:0]   gpr_wdata;
    logic [1:0][4:0]               gpr_raddr;
    logic [1:0][DATA_W-1:0]        gpr_rdata;
    logic [NUM_RM-1:0]             rm_wen;
    logic [NUM_RM-1:0][DATA_W-1:0] rm_wdata;
    logic [1:0][2:0]               rm_raddr;
    logic [1:0][DATA_W-1:0]        rm_rdata;
    logic [DATA_W-1:0]             rm_status;
    exc_req_t                      exc;

    logic        wb_fire_q, wb_fire_d;
    logic [31:0] retire_q,  retire_d;

    assign gpr_we  = is_write_in && !mov_rm_in && (rd_in != 5'd0);
    assign rm_we   = is_write_in && mov_rm_in;
    assign rm_widx = rd_in[2:0];

    assign exc.valid = exc_valid;
    assign exc.pc    = exc_pc;
    assign exc.addr  = exc_addr;
    assign exc.cause = exc_cause;

    always_comb begin
        gpr_wen = '0;
        if (gpr_we) gpr_wen[rd_in] = 1'b1;
    end

    assign gpr_wdata = {NGPR{wb_data_in}};

    // Exception commit overrides any RM write landing on indices 0..3;
    // the status entry keeps its upper bits and only sets the mode flag.
    always_comb begin
        rm_wen   = '0;
        rm_wdata = {NUM_RM{wb_data_in}};
        if (rm_we) rm_wen[rm_widx] = 1'b1;
        if (exc.valid) begin
            for (int i = 0; i < NUM_RM; i++) begin
                if (exc_owns_rm(i)) rm_wen[i] = 1'b1;
            end
            rm_wdata[RM_EPC]   = exc.pc;
            rm_wdata[RM_EADDR] = exc.addr;
            rm_wdata[RM_CAUSE] = exc.cause;
            rm_wdata[RM_STATUS] = rm_status;
            rm_wdata[RM_STATUS][RM_STATUS_EXC_BIT] = 1'b1;
        end
    end

    assign gpr_raddr = {rs2_addr, rs1_addr};

    regfile_bank #(
        .DEPTH (NGPR),
        .WIDTH (DATA_W),
        .NRD   (2)
    ) u_gpr (
        .clk     (clk),
        .reset   (reset),
        .we_i    (gpr_wen),
        .wdata_i (gpr_wdata),
        .raddr_i (gpr_raddr),
        .rdata_o (gpr_rdata)
    );

    // Second RM port is an internal tap on the status entry.
    assign rm_raddr  = {3'(RM_STATUS), rm_addr};
    assign rm_status = rm_rdata[1];

    regfile_bank #(
        .DEPTH (NUM_RM),
        .WIDTH (DATA_W),
        .NRD   (2)
    ) u_rm (
        .clk     (clk),
        .reset   (reset),
        .we_i    (rm_wen),
        .wdata_i (rm_wdata),
        .raddr_i (rm_raddr),
        .rdata_o (rm_rdata)
    );

    always_comb begin
        if (rs1_addr == 5'd0)                  rs1_data = '0;
        else if (gpr_we && rs1_addr == rd_in)  rs1_data = wb_data_in;
        else                                   rs1_data = gpr_rdata[0];

        if (rs2_addr == 5'd0)                  rs2_data = '0;
        else if (gpr_we && rs2_addr == rd_in)  rs2_data = wb_data_in;
        else                                   rs2_data = gpr_rdata[1];

        if (rm_we && rm_addr == rm_widx)       rm_data = wb_data_in;
        else                                   rm_data = rm_rdata[0];
    end

    assign wb_fire_d = is_write_in;
    assign retire_d  = is_write_in ? retire_q + 32'd1 : retire_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_fire_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            wb_fire_q <= wb_fire_d;
            retire_q  <= retire_d;
        end
    end

    assign wb_fire      = wb_fire_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: expectations queued at drive time,
// drained when the DUT output is sampled.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_data_in;
    logic [4:0]  rd_in;
    logic        is_write_in;
    logic        mov_rm_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [2:0]  rm_addr;
    logic [31:0] rm_data;
    logic        exc_valid;
    logic [31:0] exc_pc, exc_addr, exc_cause;
    logic        wb_fire;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .wb_data_in   (wb_data_in),
        .rd_in        (rd_in),
        .is_write_in  (is_write_in),
        .mov_rm_in    (mov_rm_in),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rm_addr      (rm_addr),
        .rm_data      (rm_data),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .exc_addr     (exc_addr),
        .exc_cause    (exc_cause),
        .wb_fire      (wb_fire),
        .retire_count (retire_count)
    );

    localparam int S_RS1 = 0, S_RS2 = 1, S_RM = 2, S_FIRE = 3, S_CNT = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t         sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_RS1:   return rs1_data;
            S_RS2:   return rs2_data;
            S_RM:    return rm_data;
            S_FIRE:  return {31'd0, wb_fire};
            default: return retire_count;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, sample(e.sel), e.exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; settle before any check.
    task automatic drive(input logic we, input logic mov, input logic [4:0] rd,
                         input logic [31:0] d, input logic exc);
        @(negedge clk);
        is_write_in = we; mov_rm_in = mov; rd_in = rd; wb_data_in = d;
        exc_valid = exc;
        if (we && !reset) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle_rm(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        rm_addr = idx;
        #1;
        push(tag, S_RM, exp);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        is_write_in = 0; mov_rm_in = 0; rd_in = 0; wb_data_in = 0;
        rs1_addr = 0; rs2_addr = 0; rm_addr = 0;
        exc_valid = 0; exc_pc = 0; exc_addr = 0; exc_cause = 0;

        // Write during reset is dropped.
        drive(1'b1, 1'b0, 5'd5, 32'h1234_5678, 1'b0);
        rs1_addr = 5;
        @(posedge clk);
        @(posedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        reset = 1'b0;
        #1;
        push("rst_x5", S_RS1, 32'h0);
        push("rst_cnt", S_CNT, 32'h0);
        push("rst_fire", S_FIRE, 32'h0);
        drain();

        // GPR write with bypass on both ports.
        drive(1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0);
        rs1_addr = 7; rs2_addr = 7;
        #1;
        push("byp_rs1", S_RS1, 32'hDEAD_BEEF);
        push("byp_rs2", S_RS2, 32'hDEAD_BEEF);
        drain();
        push("w7_cnt", S_CNT, exp_cnt);
        push("w7_fire", S_FIRE, 32'h1);
        edge_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        push("arr_rs1", S_RS1, 32'hDEAD_BEEF);
        push("arr_rs2", S_RS2, 32'hDEAD_BEEF);
        drain();
        push("idle_fire", S_FIRE, 32'h0);
        edge_check();

        // x0 write discarded but counted.
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        rs1_addr = 0;
        #1;
        push("x0_byp", S_RS1, 32'h0);
        drain();
        push("x0_cnt", S_CNT, exp_cnt);
        edge_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        push("x0_arr", S_RS1, 32'h0);
        drain();

        // RM routing: rd 0x0C lands in rm4, gpr12 untouched.
        drive(1'b1, 1'b1, 5'h0C, 32'h0000_A5A5, 1'b0);
        rm_addr = 4; rs1_addr = 12;
        #1;
        push("rm4_byp", S_RM, 32'h0000_A5A5);
        push("g12_nobyp", S_RS1, 32'h0);
        drain();
        push("rm4_cnt", S_CNT, exp_cnt);
        edge_check();
        idle_rm(3'd4, 32'h0000_A5A5, "rm4_arr");
        push("g12_arr", S_RS1, 32'h0);
        drain();

        // Preload status upper bits, then exception racing an RM write to rm0.
        drive(1'b1, 1'b1, 5'd3, 32'h0000_00F0, 1'b0);
        edge_check();
        drive(1'b1, 1'b1, 5'd0, 32'h0000_0055, 1'b1);
        exc_pc = 32'h100; exc_addr = 32'h2000; exc_cause = 32'h3;
        edge_check();
        idle_rm(3'd0, 32'h100, "exc_rm0");
        idle_rm(3'd1, 32'h2000, "exc_rm1");
        idle_rm(3'd2, 32'h3, "exc_rm2");
        idle_rm(3'd3, 32'hF1, "exc_rm3");

        // Exception with RM write to rm5: both commit.
        drive(1'b1, 1'b1, 5'd5, 32'h0000_0077, 1'b1);
        exc_pc = 32'h200; exc_addr = 32'h2100; exc_cause = 32'h4;
        edge_check();
        idle_rm(3'd5, 32'h77, "exc_rm5");
        idle_rm(3'd0, 32'h200, "exc2_rm0");

        // Exception with a GPR write: GPR commits.
        drive(1'b1, 1'b0, 5'd9, 32'h0000_0099, 1'b1);
        exc_pc = 32'h300;
        edge_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        rs2_addr = 9; rm_addr = 0;
        #1;
        push("exc_x9", S_RS2, 32'h99);
        push("exc3_rm0", S_RM, 32'h300);
        push("exc_cnt", S_CNT, exp_cnt);
        drain();

        // Clear exception mode.
        drive(1'b1, 1'b1, 5'd3, 32'h0, 1'b0);
        edge_check();
        idle_rm(3'd3, 32'h0, "clr_rm3");

        // Counter wrap from a forced preload.
        @(negedge clk);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        exp_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 5'd10, 32'h1, 1'b0);
        push("wrap_cnt", S_CNT, exp_cnt);
        push("wrap_fire", S_FIRE, 32'h1);
        edge_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
